// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the memory arbiter family: FSM state
// encodings, grant-index width helper and stall-counter width.
package arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Index width for a port count; at least one bit so two ports still work.
    function automatic int grant_bits(input int n);
        int b;
        b = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << b) < n) b = b + 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: searches upward from last_grant+1 with
// an explicit wrap at N-1, so non power-of-two port counts never alias.
module rr_priority_select #(
    parameter int N  = 2,
    parameter int GB = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GB-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [GB-1:0] grant_idx,
    output logic          any_req
);

    // First requester after last_grant wins; one-hot and index produced together.
    always_comb begin
        int c;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        c         = int'(last_grant);
        for (int k = 0; k < N; k++) begin
            c = (c >= N - 1) ? 0 : c + 1;
            if (!any_req && req[c]) begin
                any_req   = 1'b1;
                grant_idx = GB'(c);
                grant[c]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_port_memory_arbiter.sv
// Shares one memory port among NUM_PORTS requesters with round-robin
// arbitration, a single outstanding transaction, and read responses routed
// back to the issuing port.
// Optional build macro ARB_STALL_COUNT_EN adds per-port saturating stall
// counters on output stall_count.
module multi_port_memory_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                req_read,
    input  logic [NUM_PORTS-1:0]                req_write,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_byte_en,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0]   req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_PORTS-1:0]                req_ready,
    output logic [NUM_PORTS-1:0]                resp_valid,
    output logic [DATA_WIDTH-1:0]               resp_data,
    output logic [ADDRESS_BITS-1:0]             resp_address,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [DATA_WIDTH/8-1:0]             mem_byte_en,
    output logic [ADDRESS_BITS-1:0]             mem_address,
    output logic [DATA_WIDTH-1:0]               mem_data_out,
    input  logic                                mem_ready,
    input  logic                                mem_valid,
    input  logic [DATA_WIDTH-1:0]               mem_data_in,
    input  logic [ADDRESS_BITS-1:0]             mem_address_in
`ifdef ARB_STALL_COUNT_EN
    ,
    output logic [NUM_PORTS*STALL_CNT_W-1:0]    stall_count
`endif
);

    localparam int GB   = grant_bits(NUM_PORTS);
    localparam int BE_W = DATA_WIDTH / 8;

    arb_state_t                               state;
    logic [GB-1:0]                            last_grant;
    logic                                     hold_read;
    logic                                     hold_write;
    logic [BE_W-1:0]                          hold_be;
    logic [ADDRESS_BITS-1:0]                  hold_addr;
    logic [DATA_WIDTH-1:0]                    hold_data;

    logic [NUM_PORTS-1:0]                     req_any;
    logic [NUM_PORTS-1:0]                     sel_grant;
    logic [GB-1:0]                            sel_idx;
    logic                                     sel_any;

    // Per-port views of the flat request buses.
    logic [NUM_PORTS-1:0][BE_W-1:0]           be_v;
    logic [NUM_PORTS-1:0][ADDRESS_BITS-1:0]   addr_v;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     data_v;

    assign be_v    = req_byte_en;
    assign addr_v  = req_address;
    assign data_v  = req_data;
    assign req_any = req_read | req_write;

    rr_priority_select #(
        .N  (NUM_PORTS),
        .GB (GB)
    ) u_sel (
        .req        (req_any),
        .last_grant (last_grant),
        .grant      (sel_grant),
        .grant_idx  (sel_idx),
        .any_req    (sel_any)
    );

    // Accept pulse only while arbitrating and out of reset.
    assign req_ready = (state == ARB && reset) ? sel_grant : '0;

    // Shared port is driven straight from the hold registers; the command
    // strobes are only live while issuing.
    assign mem_read     = (state == ISSUE) && hold_read;
    assign mem_write    = (state == ISSUE) && hold_write;
    assign mem_byte_en  = hold_be;
    assign mem_address  = hold_addr;
    assign mem_data_out = hold_data;

    // Arbitration / issue / response FSM with registered hold and response state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= ARB;
            last_grant   <= GB'(NUM_PORTS - 1);
            hold_read    <= 1'b0;
            hold_write   <= 1'b0;
            hold_be      <= '0;
            hold_addr    <= '0;
            hold_data    <= '0;
            resp_valid   <= '0;
            resp_data    <= '0;
            resp_address <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                ARB: begin
                    if (sel_any) begin
                        // Write takes precedence when a port raises both.
                        hold_write <= req_write[sel_idx];
                        hold_read  <= req_read[sel_idx] & ~req_write[sel_idx];
                        hold_be    <= be_v[sel_idx];
                        hold_addr  <= addr_v[sel_idx];
                        hold_data  <= data_v[sel_idx];
                        last_grant <= sel_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) state <= hold_write ? ARB : WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        resp_data    <= mem_data_in;
                        resp_address <= mem_address_in;
                        resp_valid   <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << last_grant;
                        state        <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

`ifdef ARB_STALL_COUNT_EN
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stall
        logic [STALL_CNT_W-1:0] cnt;

        // Count cycles this port waits with a request up; saturate at all-ones.
        always_ff @(posedge clock) begin
            if (!reset) begin
                cnt <= '0;
            end else if (req_any[i] && !req_ready[i] && cnt != {STALL_CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stall_count[i*STALL_CNT_W +: STALL_CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_multi_port_memory_arbiter.sv
// Directed bench for multi_port_memory_arbiter, NUM_PORTS=4, 32-bit buses.
// Stall-counter checks are compiled in with ARB_STALL_COUNT_EN.
module tb_multi_port_memory_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic                 clock;
    logic                 reset;
    logic [NP-1:0]        req_read;
    logic [NP-1:0]        req_write;
    logic [NP*DW/8-1:0]   req_byte_en;
    logic [NP*AW-1:0]     req_address;
    logic [NP*DW-1:0]     req_data;
    logic [NP-1:0]        req_ready;
    logic [NP-1:0]        resp_valid;
    logic [DW-1:0]        resp_data;
    logic [AW-1:0]        resp_address;
    logic                 mem_read;
    logic                 mem_write;
    logic [DW/8-1:0]      mem_byte_en;
    logic [AW-1:0]        mem_address;
    logic [DW-1:0]        mem_data_out;
    logic                 mem_ready;
    logic                 mem_valid;
    logic [DW-1:0]        mem_data_in;
    logic [AW-1:0]        mem_address_in;
`ifdef ARB_STALL_COUNT_EN
    logic [NP*16-1:0]     stall_count;
`endif

    int vectors;
    int miscompares;

    multi_port_memory_arbiter #(
        .NUM_PORTS    (NP),
        .DATA_WIDTH   (DW),
        .ADDRESS_BITS (AW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_byte_en    (req_byte_en),
        .req_address    (req_address),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_address   (resp_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_en    (mem_byte_en),
        .mem_address    (mem_address),
        .mem_data_out   (mem_data_out),
        .mem_ready      (mem_ready),
        .mem_valid      (mem_valid),
        .mem_data_in    (mem_data_in),
        .mem_address_in (mem_address_in)
`ifdef ARB_STALL_COUNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order [5];
        logic [AW-1:0] a;
        vectors     = 0;
        miscompares = 0;
        order       = '{0, 1, 2, 3, 0};

        reset          = 1'b0;
        req_read       = '0;
        req_write      = '0;
        req_byte_en    = '0;
        req_address    = '0;
        req_data       = '0;
        mem_ready      = 1'b0;
        mem_valid      = 1'b0;
        mem_data_in    = '0;
        mem_address_in = '0;
        for (int p = 0; p < NP; p++) req_address[p*AW +: AW] = 32'h1000 + 32'(p * 4);

        // Reset held three cycles with every port requesting.
        @(negedge clock);
        req_read = 4'hF;
        repeat (3) tick();
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(4'b0000));
        chk("rst_mem_read", 128'(mem_read), 128'(1'b0));
        chk("rst_mem_write", 128'(mem_write), 128'(1'b0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(4'b0000));
        chk("rst_resp_data", 128'(resp_data), 128'(32'h0));
        reset = 1'b1;

        // Continuous requests: grants rotate 0,1,2,3,0, each a full read.
        for (int i = 0; i < 5; i++) begin
            a = 32'h1000 + 32'(order[i] * 4);
            #1;
            chk($sformatf("rr_ready_%0d", i), 128'(req_ready), 128'(4'b0001 << order[i]));
            tick();
            chk($sformatf("rr_mem_read_%0d", i), 128'(mem_read), 128'(1'b1));
            chk($sformatf("rr_mem_addr_%0d", i), 128'(mem_address), 128'(a));
            mem_ready = 1'b1;
            tick();
            mem_ready      = 1'b0;
            mem_valid      = 1'b1;
            mem_data_in    = 32'hC0DE0000 + 32'(i);
            mem_address_in = a;
            tick();
            mem_valid = 1'b0;
            #1;
            chk($sformatf("rr_resp_valid_%0d", i), 128'(resp_valid), 128'(4'b0001 << order[i]));
            chk($sformatf("rr_resp_data_%0d", i), 128'(resp_data), 128'(32'hC0DE0000 + 32'(i)));
        end
        req_read = '0;
        tick();

        // Single read on port 2: response lands in the fourth cycle.
        req_read = 4'b0100;
        req_address[2*AW +: AW] = 32'h100;
        #1;
        chk("lat_ready", 128'(req_ready), 128'(4'b0100));
        tick();
        req_read  = '0;
        mem_ready = 1'b1;
        #1;
        chk("lat_mem_read", 128'(mem_read), 128'(1'b1));
        chk("lat_mem_addr", 128'(mem_address), 128'(32'h100));
        tick();
        mem_ready      = 1'b0;
        mem_valid      = 1'b1;
        mem_data_in    = 32'hDEADBEEF;
        mem_address_in = 32'h100;
        #1;
        chk("lat_no_early_resp", 128'(resp_valid), 128'(4'b0000));
        chk("lat_wait_no_read", 128'(mem_read), 128'(1'b0));
        tick();
        mem_valid = 1'b0;
        #1;
        chk("lat_resp_valid", 128'(resp_valid), 128'(4'b0100));
        chk("lat_resp_data", 128'(resp_data), 128'(32'hDEADBEEF));
        chk("lat_resp_addr", 128'(resp_address), 128'(32'h100));
        tick();
        chk("lat_pulse_one_cycle", 128'(resp_valid), 128'(4'b0000));
        chk("lat_data_held", 128'(resp_data), 128'(32'hDEADBEEF));

        // Port 1 raises read and write together: treated as a write, stalled 5 cycles.
        req_read  = 4'b0010;
        req_write = 4'b0010;
        req_address[1*AW +: AW]   = 32'h200;
        req_data[1*DW +: DW]      = 32'hA5A5A5A5;
        req_byte_en[1*4 +: 4]     = 4'b0011;
        #1;
        chk("wr_ready", 128'(req_ready), 128'(4'b0010));
        tick();
        req_read  = '0;
        req_write = '0;
        req_data[1*DW +: DW]  = 32'h0;
        req_byte_en[1*4 +: 4] = 4'b0000;
        mem_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) mem_ready = 1'b1;
            #1;
            chk($sformatf("wr_stable_%0d", c),
                {58'd0, mem_write, mem_read, mem_byte_en, mem_address, mem_data_out},
                {58'd0, 1'b1, 1'b0, 4'b0011, 32'h200, 32'hA5A5A5A5});
            tick();
        end
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("wr_back_idle", 128'(mem_write), 128'(1'b0));
        chk("wr_no_resp", 128'(resp_valid), 128'(4'b0000));
        tick();
        chk("wr_no_resp_late", 128'(resp_valid), 128'(4'b0000));

        // Reset while waiting on read data abandons the read.
        req_read = 4'b1000;
        #1;
        chk("abort_ready", 128'(req_ready), 128'(4'b1000));
        tick();
        req_read  = '0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        reset     = 1'b0;
        tick();
        reset          = 1'b1;
        mem_valid      = 1'b1;
        mem_data_in    = 32'h12345678;
        mem_address_in = 32'h1000 + 32'd12;
        tick();
        mem_valid = 1'b0;
        #1;
        chk("abort_no_resp", 128'(resp_valid), 128'(4'b0000));
        chk("abort_resp_cleared", 128'(resp_data), 128'(32'h0));
        req_read = 4'b1010;
        #1;
        chk("abort_arb_prio", 128'(req_ready), 128'(4'b0010));
        chk("abort_idle_port", 128'(mem_read), 128'(1'b0));
        req_read = '0;

`ifdef ARB_STALL_COUNT_EN
        // Port 2 held off while port 0 write sits in ISSUE.
        req_write = 4'b0001;
        tick();
        req_write = '0;
        req_read  = 4'b0100;
        repeat (7) tick();
        chk("stall_7", 128'(stall_count[2*16 +: 16]), 128'(16'd7));
        repeat (70000) tick();
        chk("stall_sat", 128'(stall_count[2*16 +: 16]), 128'(16'hFFFF));
        req_read  = '0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
